// File: rtl/add_fp_pkg.sv
// Shared constants and types for the fp64 add path and its retire stage.
package add_fp_pkg;

  localparam int LATENCY_FP64 = 4;

  typedef enum logic [2:0] {
    RTE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rnd_mode_e;

  typedef struct packed {
    logic nv;
    logic of;
  } fp_flags_t;

  // Default-width retire record; the top packs the same field order for any TAG_W.
  localparam int RETIRE_TAG_W = 4;

  typedef struct packed {
    logic [RETIRE_TAG_W-1:0] tag;
    logic [63:0]             result;
    fp_flags_t               flags;
  } retire_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO over a flat register array; the extra pointer MSB
// separates full from empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/add_fp64_retire.sv
// Retire stage behind the non-stallable add_fp64: credit-gated issue, tag delay
// line matching the adder latency, result FIFO and sticky exception flags.
module add_fp64_retire
  import add_fp_pkg::*;
#(
  parameter int LATENCY = LATENCY_FP64,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [TAG_W-1:0]           issue_tag,
  output logic                       issue_ready,
  output logic                       fp_en,
  input  logic [63:0]                fp_result,
  input  logic                       fp_nv,
  input  logic                       fp_of,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [63:0]                out_result,
  output logic                       out_nv,
  output logic                       out_of,
  input  logic                       fflags_clr,
  output logic                       fflags_nv,
  output logic                       fflags_of,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = TAG_W + 64 + 2;

  logic             vld_p [LATENCY];
  logic [TAG_W-1:0] tag_p [LATENCY];
  logic [CW-1:0]    in_flight;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             wr_en;
  logic             pop;
  fp_flags_t        wr_flags;
  fp_flags_t        head_flags;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    head_entry;
  logic [TAG_W-1:0] head_tag;
  logic [63:0]      head_result;

  // Credit counts ops in flight against free FIFO slots, so a landing result
  // always finds room; a same-cycle pop is only credited one cycle later.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++) in_flight += CW'(vld_p[i]);
  end

  assign occupancy   = fifo_count + in_flight;
  assign issue_ready = (occupancy < CW'(DEPTH));
  assign fp_en       = issue_valid & issue_ready;

  // Delay line: stage 0 samples alongside the adder, last stage aligns with fp_result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= fp_en;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_p[0] <= issue_tag;
    for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
  end

  // Capture into the result FIFO.
  assign wr_en    = vld_p[LATENCY-1];
  assign wr_flags = '{nv: fp_nv, of: fp_of};
  assign wr_entry = {tag_p[LATENCY-1], fp_result, wr_flags};
  assign pop      = out_valid & out_ready;

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_en),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_tag, head_result, head_flags} = head_entry;

  // Head fields read as zero while empty so stale storage never shows.
  assign out_valid  = ~fifo_empty;
  assign out_tag    = out_valid ? head_tag    : '0;
  assign out_result = out_valid ? head_result : '0;
  assign out_nv     = out_valid & head_flags.nv;
  assign out_of     = out_valid & head_flags.of;

  // Sticky flags: a coincident set overrides the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fflags_nv <= 1'b0;
      fflags_of <= 1'b0;
    end else begin
      fflags_nv <= (fflags_nv & ~fflags_clr) | (wr_en & fp_nv);
      fflags_of <= (fflags_of & ~fflags_clr) | (wr_en & fp_of);
    end
  end

endmodule

// File: tb/tb_add_fp64_retire.sv
// Bench for add_fp64_retire: behavioural fp64 adder stub upstream, queue-based
// reference of the retire behaviour, per-cycle compare plus directed literals.
module tb_add_fp64_retire;

  localparam logic [63:0] P_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] N_INF  = 64'hFFF0000000000000;
  localparam logic [63:0] QNAN   = 64'h7FF8000000000000;
  localparam logic [63:0] MAXF   = 64'h7FEFFFFFFFFFFFFF;
  localparam logic [63:0] HALF   = 64'h3FE0000000000000;
  localparam logic [63:0] ONE    = 64'h3FF0000000000000;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_tag;
  logic        issue_ready;
  logic        fp_en;
  logic [63:0] fp_result;
  logic        fp_nv;
  logic        fp_of;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_tag;
  logic [63:0] out_result;
  logic        out_nv;
  logic        out_of;
  logic        fflags_clr;
  logic        fflags_nv;
  logic        fflags_of;
  logic [3:0]  occupancy;

  logic [63:0] src1;
  logic [63:0] src2;

  int n_chk  = 0;
  int n_pass = 0;

  add_fp64_retire #(.LATENCY(4), .DEPTH(8), .TAG_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .fp_en       (fp_en),
    .fp_result   (fp_result),
    .fp_nv       (fp_nv),
    .fp_of       (fp_of),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tag     (out_tag),
    .out_result  (out_result),
    .out_nv      (out_nv),
    .out_of      (out_of),
    .fflags_clr  (fflags_clr),
    .fflags_nv   (fflags_nv),
    .fflags_of   (fflags_of),
    .occupancy   (occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // IEEE-754 double add, round-to-nearest-even; returns {nv, of, result}.
  function automatic logic [65:0] fadd(input logic [63:0] a, input logic [63:0] b);
    logic        ai, bi, an, bn, ofl;
    logic [63:0] r;
    ai = (a[62:0] == P_INF[62:0]);
    bi = (b[62:0] == P_INF[62:0]);
    an = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    bn = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    if (an || bn || (ai && bi && (a[63] != b[63]))) return {1'b1, 1'b0, QNAN};
    r   = $realtobits($bitstoreal(a) + $bitstoreal(b));
    ofl = (r[62:0] == P_INF[62:0]) && !ai && !bi;
    return {1'b0, ofl, r};
  endfunction

  // Adder stub: 4 edges from sample to capture; idle slots carry junk.
  logic [65:0] add_pipe [4];
  always @(posedge clock) begin
    add_pipe[0] <= fp_en ? fadd(src1, src2) : {1'b1, 1'b1, 64'hDEADBEEFCAFEF00D};
    add_pipe[1] <= add_pipe[0];
    add_pipe[2] <= add_pipe[1];
    add_pipe[3] <= add_pipe[2];
  end
  assign {fp_nv, fp_of, fp_result} = add_pipe[3];

  // Reference: every accepted op becomes visible 4 edges later and leaves in order.
  typedef struct {
    logic [3:0]  tag;
    logic [63:0] res;
    logic        nv;
    logic        of;
    int          arr;
  } op_t;

  op_t  q[$];
  int   e_cnt = 0;
  logic m_nv = 1'b0;
  logic m_of = 1'b0;

  initial begin
    forever begin
      int   occ;
      logic hv, rdy, acc, popm, snv, sof;
      op_t  op;
      logic [65:0] r;
      @(negedge clock);
      if (reset) begin
        q.delete();
        m_nv = 1'b0;
        m_of = 1'b0;
      end
      occ = q.size();
      hv  = (q.size() > 0) && (q[0].arr <= e_cnt);
      rdy = (occ < 8);
      chk("issue_ready", 66'(issue_ready), 66'(rdy));
      chk("fp_en", 66'(fp_en), 66'(issue_valid && rdy && !reset));
      chk("occupancy", 66'(occupancy), 66'(occ));
      chk("out_valid", 66'(out_valid), 66'(hv));
      chk("fflags_nv", 66'(fflags_nv), 66'(m_nv));
      chk("fflags_of", 66'(fflags_of), 66'(m_of));
      if (hv) begin
        chk("out_tag", 66'(out_tag), 66'(q[0].tag));
        chk("out_result", 66'(out_result), 66'(q[0].res));
        chk("out_flags", 66'({out_nv, out_of}), 66'({q[0].nv, q[0].of}));
      end
      if (reset) begin
        chk("rst_head", {out_nv, out_of, out_result}, 66'd0);
        chk("rst_tag", 66'(out_tag), 66'd0);
      end else begin
        acc  = issue_valid && rdy;
        popm = hv && out_ready;
        snv  = 1'b0;
        sof  = 1'b0;
        foreach (q[i]) if (q[i].arr == e_cnt + 1) begin
          snv = q[i].nv;
          sof = q[i].of;
        end
        m_nv = (m_nv & ~fflags_clr) | snv;
        m_of = (m_of & ~fflags_clr) | sof;
        if (popm) void'(q.pop_front());
        if (acc) begin
          r      = fadd(src1, src2);
          op.tag = issue_tag;
          op.res = r[63:0];
          op.nv  = r[65];
          op.of  = r[64];
          op.arr = e_cnt + 1 + 4;
          q.push_back(op);
        end
      end
      e_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] t, input logic [63:0] a, input logic [63:0] b);
    issue_valid = 1'b1;
    issue_tag   = t;
    src1        = a;
    src2        = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_tag   = '0;
    src1        = '0;
    src2        = '0;
    out_ready   = 1'b0;
    fflags_clr  = 1'b0;

    // Literal pins on the reference adder.
    chk("pin_inf_minus_inf", fadd(P_INF, N_INF), {1'b1, 1'b0, QNAN});
    chk("pin_max_plus_max", fadd(MAXF, MAXF), {1'b0, 1'b1, P_INF});
    chk("pin_3_plus_half", fadd(64'h4008000000000000, HALF), {2'b00, 64'h400C000000000000});

    step();
    step();
    chk("reset_ready", 66'(issue_ready), 66'd1);
    chk("reset_occ", 66'(occupancy), 66'd0);
    chk("reset_valid", 66'(out_valid), 66'd0);
    reset = 1'b0;
    step();

    // Single op: +Inf + -Inf with tag 3.
    issue(4'd3, P_INF, N_INF);
    step();
    issue_valid = 1'b0;
    step();
    step();
    step();
    chk("single_not_yet", 66'(out_valid), 66'd0);
    step();
    chk("single_valid", 66'(out_valid), 66'd1);
    chk("single_tag", 66'(out_tag), 66'd3);
    chk("single_result", 66'(out_result), 66'(QNAN));
    chk("single_nv", 66'(out_nv), 66'd1);
    chk("single_sticky_nv", 66'(fflags_nv), 66'd1);
    out_ready = 1'b1;
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("single_cleared", 66'(fflags_nv), 66'd0);

    // Streaming at one op per cycle.
    for (int i = 0; i < 20; i++) begin
      issue(4'(i % 16), $realtobits(real'(i)), HALF);
      step();
    end
    issue_valid = 1'b0;
    repeat (8) step();
    chk("stream_drained", 66'(occupancy), 66'd0);

    // Backpressure: credit stops issue at exactly DEPTH ops.
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      issue(4'(i), $realtobits(real'(100 + i)), ONE);
      #1;
      if (fp_en) acc_cnt++;
      step();
    end
    chk("bp_accepted", 66'(acc_cnt), 66'd8);
    chk("bp_occ_full", 66'(occupancy), 66'd8);
    chk("bp_not_ready", 66'(issue_ready), 66'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_pop_not_credited", 66'(issue_ready), 66'd0);
    step();
    chk("bp_resumed", 66'(issue_ready), 66'd1);
    for (int i = 0; i < 10; i++) begin
      issue(4'(12 + i), $realtobits(real'(200 + i)), ONE);
      step();
    end
    issue_valid = 1'b0;
    repeat (14) step();
    chk("bp_drained", 66'(occupancy), 66'd0);

    // Sticky overflow landing on the same edge as a clear pulse.
    issue(4'd9, MAXF, MAXF);
    step();
    issue_valid = 1'b0;
    step();
    step();
    step();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("sticky_set_wins", 66'(fflags_of), 66'd1);
    chk("sticky_nv_clean", 66'(fflags_nv), 66'd0);
    repeat (3) step();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("sticky_lone_clear", 66'(fflags_of), 66'd0);

    // Reset mid-flight with exception-raising ops.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(4'(5 + i), P_INF, N_INF);
      step();
    end
    issue_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midrst_valid", 66'(out_valid), 66'd0);
    chk("midrst_occ", 66'(occupancy), 66'd0);
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("post_rst_valid", 66'(out_valid), 66'd0);
    chk("post_rst_occ", 66'(occupancy), 66'd0);
    chk("post_rst_flags", 66'({fflags_nv, fflags_of}), 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
